// File: rtl/monobit_pkg.sv
// Shared types and constants for the monobit frequency-test sequencer.
// Contents:
//   state_e      - controller state encoding (IDLE, COLLECT, EVAL, REPORT)
//   LEN_W_DEF    - default width of block length / ones count / |S|
//   THR_W_DEF    - default width of the pass threshold
//   diff_w()     - width of the signed 2*ones - len intermediate
package monobit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        REPORT  = 2'd3
    } state_e;

    localparam int LEN_W_DEF = 8;
    localparam int THR_W_DEF = 8;

    // 2*ones needs one extra bit and the sign needs another.
    function automatic int diff_w(input int len_w);
        return len_w + 2;
    endfunction

endpackage

// File: rtl/monobit_abs_stat.sv
// Combinational |2*ones - len| for one block of the monobit test.
// Ports:
//   ones     in  LEN_W  number of ones seen in the block
//   len      in  LEN_W  block length in bits
//   abs_diff out LEN_W  |2*ones - len|; fits because ones <= len
module monobit_abs_stat
    import monobit_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic [LEN_W-1:0] ones,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] abs_diff
);

    localparam int DW = diff_w(LEN_W);

    logic signed [DW-1:0] diff;
    logic        [DW-1:0] mag;

    assign diff     = $signed({1'b0, ones, 1'b0}) - $signed({2'b00, len});
    assign mag      = diff[DW-1] ? DW'(-diff) : DW'(diff);
    // Upper bits of mag are always zero since |diff| <= len.
    assign abs_diff = mag[LEN_W-1:0];

endmodule

// File: rtl/monobit_seq_ctrl.sv
// Block framing, ones counting and pass/fail reporting for the monobit
// frequency test.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ena                 global enable; all state holds while low
//   start               begin a test when idle (level, sampled each cycle)
//   cfg_len, cfg_thresh block length and |S| threshold, latched at start
//   bit_in, bit_valid   serial data and its qualifier
//   busy                test in progress
//   done                one-cycle result strobe
//   pass, err           result flags (err: zero-length block requested)
//   ones_cnt, stat_abs  ones in the last block and |2*ones - len|
module monobit_seq_ctrl
    import monobit_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int THR_W = THR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [THR_W-1:0] cfg_thresh,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic [LEN_W-1:0] ones_cnt,
    output logic [LEN_W-1:0] stat_abs
);

    localparam int CW = (LEN_W > THR_W) ? LEN_W : THR_W;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [THR_W-1:0] thr_q, thr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] ones_q, ones_d;
    logic [LEN_W-1:0] stat_q, stat_d;
    logic             pass_q, pass_d;
    logic             err_q, err_d;

    logic [LEN_W-1:0] abs_diff;
    logic [CW-1:0]    abs_ext, thr_ext;

    monobit_abs_stat #(.LEN_W(LEN_W)) u_abs (
        .ones     (ones_q),
        .len      (len_q),
        .abs_diff (abs_diff)
    );

    assign abs_ext = CW'(abs_diff);
    assign thr_ext = CW'(thr_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        stat_d  = stat_q;
        pass_d  = pass_q;
        err_d   = err_q;
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        ones_d = '0;
                        if (cfg_len == '0) begin
                            // Degenerate block: report an error immediately.
                            err_d   = 1'b1;
                            pass_d  = 1'b0;
                            stat_d  = '0;
                            state_d = REPORT;
                        end else begin
                            // stat/pass/err keep the previous result until EVAL.
                            len_d   = cfg_len;
                            thr_d   = cfg_thresh;
                            cnt_d   = '0;
                            state_d = COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (bit_valid) begin
                        cnt_d  = cnt_q + LEN_W'(1);
                        ones_d = ones_q + LEN_W'(bit_in);
                        if (cnt_q == len_q - LEN_W'(1)) state_d = EVAL;
                    end
                end
                EVAL: begin
                    stat_d  = abs_diff;
                    pass_d  = (abs_ext <= thr_ext);
                    err_d   = 1'b0;
                    state_d = REPORT;
                end
                REPORT: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            thr_q   <= '0;
            cnt_q   <= '0;
            ones_q  <= '0;
            stat_q  <= '0;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            stat_q  <= stat_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q != IDLE);
    // Gated by ena so a stalled REPORT cycle does not emit a pulse.
    assign done     = ena && (state_q == REPORT);
    assign pass     = pass_q;
    assign err      = err_q;
    assign ones_cnt = ones_q;
    assign stat_abs = stat_q;

endmodule

// File: tb/tb_monobit_seq_ctrl.sv
module tb_monobit_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, bit_in, bit_valid;
    logic [7:0] cfg_len, cfg_thresh;
    logic       busy, done, pass, err;
    logic [7:0] ones_cnt, stat_abs;

    monobit_seq_ctrl #(.LEN_W(8), .THR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .cfg_len    (cfg_len),
        .cfg_thresh (cfg_thresh),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err        (err),
        .ones_cnt   (ones_cnt),
        .stat_abs   (stat_abs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ones;
        int stat;
        int pass;
        int err;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   bitbuf[256];
    int   last_ones = 0, last_stat = 0, last_pass = 0, last_err = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("ones_cnt", int'(ones_cnt), mon_e.ones);
                chk("stat_abs", int'(stat_abs), mon_e.stat);
                chk("pass", int'(pass), mon_e.pass);
                chk("err", int'(err), mon_e.err);
                chk("busy_report", int'(busy), 1);
            end
        end
    end

    task automatic wait_done();
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected %0d pending results", q.size());
            q.delete();
        end
    endtask

    // Drive one test; expectations come from counting bitbuf[0..len-1].
    task automatic run_test(input int len, input int thr, input int gap_pct,
                            input int ena_pct, input int rep_pct, input int ena_gap_at);
        int ones, stat, i, last_edge, gapn;
        start = 1'b1; cfg_len = len[7:0]; cfg_thresh = thr[7:0];
        @(posedge clk); #1;
        start = 1'b0; cfg_len = 8'($urandom); cfg_thresh = 8'($urandom);
        if (len == 0) begin
            q.push_back('{0, 0, 0, 1, cyc});
            last_ones = 0; last_stat = 0; last_pass = 0; last_err = 1;
        end else begin
            chk("start_clear_ones", int'(ones_cnt), 0);
            chk("start_hold_stat", int'(stat_abs), last_stat);
            chk("start_hold_pass", int'(pass), last_pass);
            chk("start_hold_err", int'(err), last_err);
            chk("start_busy", int'(busy), 1);
            ones = 0;
            for (int b = 0; b < len; b++) ones += bitbuf[b];
            stat = 2 * ones - len;
            if (stat < 0) stat = -stat;
            i = 0; last_edge = 0; gapn = 0;
            while (i < len) begin
                ena = 1'b1; bit_valid = 1'b0; bit_in = 1'($urandom);
                start = ($urandom_range(99) < rep_pct);
                cfg_len = 8'($urandom);
                if (i == ena_gap_at && gapn < 3) begin
                    ena = 1'b0; bit_valid = 1'b1; bit_in = 1'b1; gapn++;
                end else if ($urandom_range(99) < ena_pct) begin
                    ena = 1'b0; bit_valid = 1'b1;
                end else if ($urandom_range(99) < gap_pct) begin
                    bit_valid = 1'b0;
                end else begin
                    bit_valid = 1'b1; bit_in = bitbuf[i][0]; i++;
                end
                @(posedge clk); #1;
                if (i == len) last_edge = cyc;
                else chk("busy_collect", int'(busy), 1);
            end
            ena = 1'b1; bit_valid = 1'b0; start = 1'b0;
            q.push_back('{ones, stat, (stat <= thr) ? 1 : 0, 0, last_edge + 1});
            last_ones = ones; last_stat = stat; last_pass = (stat <= thr) ? 1 : 0; last_err = 0;
        end
        wait_done();
    endtask

    task automatic fill(input int len, input int mode);
        // mode 0: random, 1: all ones
        for (int b = 0; b < 256; b++) bitbuf[b] = (mode == 1) ? 1 : ((b < len) ? int'($urandom_range(1)) : 0);
    endtask

    initial begin
        int len, thr;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        cfg_len = 8'd0; cfg_thresh = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ones", int'(ones_cnt), 0);
        chk("rst_stat", int'(stat_abs), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: ones=6 of 8 -> |S|=4 > 2
        bitbuf[0:7] = '{1, 0, 1, 1, 0, 1, 1, 1};
        run_test(8, 2, 0, 0, 0, -1);
        // 2: balanced block with stall gaps
        bitbuf[0:7] = '{1, 0, 1, 0, 0, 1, 1, 0};
        run_test(8, 0, 50, 0, 0, -1);
        // 3: widest block
        fill(255, 1);
        run_test(255, 255, 0, 0, 0, -1);
        run_test(255, 254, 0, 0, 0, -1);
        // 4: zero length
        run_test(0, 7, 0, 0, 0, -1);

        // 5: reset in the middle of a block discards it
        start = 1'b1; cfg_len = 8'd16; cfg_thresh = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bit_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ones", int'(ones_cnt), 0);
        chk("midrst_stat", int'(stat_abs), 0);
        chk("midrst_pass", int'(pass), 0);
        chk("midrst_err", int'(err), 0);
        last_ones = 0; last_stat = 0; last_pass = 0; last_err = 0;
        fill(4, 1);
        run_test(4, 3, 0, 0, 0, -1);

        // 6: ena gating mid-block, start re-pulsed while busy
        fill(12, 0);
        run_test(12, 2, 0, 0, 0, 3);
        fill(10, 0);
        run_test(10, 1, 20, 0, 60, -1);
        // bit_valid while idle is dropped
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bit_valid = 1'b0;
        chk("idle_bits_ones", int'(ones_cnt), last_ones);
        chk("idle_bits_busy", int'(busy), 0);

        // Randomized blocks
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(19))
                0, 1:    len = 0;
                2:       len = 255;
                default: len = int'($urandom_range(24, 1));
            endcase
            thr = int'($urandom_range(12));
            if ($urandom_range(9) == 0) thr = int'($urandom_range(255));
            fill(len, 0);
            run_test(len, thr, 25, 10, 15, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
